// File: rtl/spi_frame_rx.sv
// SPI sample-frame receiver: synchronises sck/mosi/cs into clk, rebuilds 3-word packets (header, AD_1, AD_2).
// Optional header compare is enabled by defining SPI_RX_HDR_CHECK_EN.
module spi_frame_rx #(
  parameter int                WORD_W   = 14,
  parameter logic [WORD_W-1:0] HDR_WORD = 14'h0FFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs,
  output logic [WORD_W-1:0] ad1,
  output logic [WORD_W-1:0] ad2,
  output logic              pair_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);

  typedef enum logic [1:0] {
    WAIT_HDR,
    WAIT_AD1,
    WAIT_AD2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2, r_mosi_s3;

  logic w_sck_rise;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_bit_en;

  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_armed;
  logic              r_word_vld;
  logic              r_len_err;
  logic [WORD_W-1:0] r_word;

  logic [WORD_W-1:0] r_ad1_hold;
  logic [WORD_W-1:0] r_ad1;
  logic [WORD_W-1:0] r_ad2;
  logic              r_pair_valid;
  logic              r_frame_err;

  logic w_pv_nxt;
  logic w_ferr_nxt;
  logic w_hold_ld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_s3  <= 1'b0;
      r_cs_s1   <= 1'b0;
      r_cs_s2   <= 1'b0;
      r_cs_s3   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_mosi_s3 <= 1'b0;
    end else begin
      r_sck_s1  <= sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_cs_s1   <= cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_mosi_s3 <= r_mosi_s2;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_s3;
  assign w_cs_fall  = ~r_cs_s2 & r_cs_s3;
  assign w_bit_en   = w_sck_rise & ~r_cs_s2 & ~w_cs_rise;

  // A cs rise only ends a frame that was opened by a cs fall; the sync flops
  // reset low, so the idle-high cs would otherwise look like a frame end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_word_vld <= 1'b0;
      r_len_err  <= 1'b0;
      r_word     <= '0;
    end else begin
      r_word_vld <= 1'b0;
      r_len_err  <= 1'b0;
      if (w_cs_fall) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else if (w_cs_rise) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
        if (r_armed) begin
          if (r_cnt == CNT_FULL) begin
            r_word_vld <= 1'b1;
            r_word     <= r_shift;
          end else begin
            r_len_err <= 1'b1;
          end
        end
      end else if (w_bit_en) begin
        r_shift <= {r_shift[WORD_W-2:0], r_mosi_s3};
        if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pv_nxt    = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_hold_ld   = 1'b0;
    if (r_len_err) begin
      w_state_nxt = WAIT_HDR;
      w_ferr_nxt  = 1'b1;
    end else if (r_word_vld) begin
      unique case (r_state)
        WAIT_HDR: begin
`ifdef SPI_RX_HDR_CHECK_EN
          if (r_word == HDR_WORD) begin
            w_state_nxt = WAIT_AD1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
`else
          w_state_nxt = WAIT_AD1;
`endif
        end
        WAIT_AD1: begin
          w_hold_ld   = 1'b1;
          w_state_nxt = WAIT_AD2;
        end
        WAIT_AD2: begin
          w_pv_nxt    = 1'b1;
          w_state_nxt = WAIT_HDR;
        end
        default: begin
          w_state_nxt = WAIT_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= WAIT_HDR;
      r_pair_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ad1_hold   <= '0;
      r_ad1        <= '0;
      r_ad2        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pair_valid <= w_pv_nxt;
      r_frame_err  <= w_ferr_nxt;
      if (w_hold_ld) begin
        r_ad1_hold <= r_word;
      end
      if (w_pv_nxt) begin
        r_ad1 <= r_ad1_hold;
        r_ad2 <= r_word;
      end
    end
  end

  assign ad1        = r_ad1;
  assign ad2        = r_ad2;
  assign pair_valid = r_pair_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != WAIT_HDR);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: bit-banged SPI packets, pair scoreboard, table vectors and directed corner cases.
module tb_spi_frame_rx;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rstn;
  logic         sck;
  logic         mosi;
  logic         cs;
  logic [W-1:0] ad1;
  logic [W-1:0] ad2;
  logic         pair_valid;
  logic         frame_err;
  logic         busy;

  spi_frame_rx #(.WORD_W(W), .HDR_WORD(14'h0FFF)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sck        (sck),
    .mosi       (mosi),
    .cs         (cs),
    .ad1        (ad1),
    .ad2        (ad2),
    .pair_valid (pair_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a1;
    logic [W-1:0] a2;
  } pair_t;

  typedef struct {
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    bit           pv;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    int           errs;
  } vec_t;

  pair_t        sb[$];
  pair_t        mon_e;
  vec_t         vt[5];
  int           n_cmp    = 0;
  int           n_bad    = 0;
  int           n_pv     = 0;
  int           n_ferr   = 0;
  int           exp_ferr = 0;
  logic         prev_pv  = 1'b0;
  logic [W-1:0] prev_ad1 = '0;
  logic [W-1:0] prev_ad2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (prev_pv) chk("pv_width", 32'(pair_valid), 32'(0));
      if (pair_valid) begin
        n_pv++;
        chk("pv_ferr_excl", 32'(frame_err), 32'(0));
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pv: got ad1=0x%0h ad2=0x%0h, expected no pair (t=%0t)", ad1, ad2, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("ad1", 32'(ad1), 32'(mon_e.a1));
          chk("ad2", 32'(ad2), 32'(mon_e.a2));
        end
      end else if (ad1 !== prev_ad1 || ad2 !== prev_ad2) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ad_hold: got %0h/%0h, expected %0h/%0h (t=%0t)", ad1, ad2, prev_ad1, prev_ad2, $time);
      end
      if (frame_err) n_ferr++;
    end
    prev_pv  = pair_valid;
    prev_ad1 = ad1;
    prev_ad2 = ad2;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int nbits, input int hp,
                            input bit close, input bit measure);
    int lat;
    lat = 0;
    cs  = 1'b0;
    sck = 1'b0;
    tick(hp);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = d[i];
      tick(hp);
      sck = 1'b1;
      tick(hp);
      sck = 1'b0;
    end
    if (close) begin
      tick(hp);
      cs = 1'b1;
      if (measure) begin
        for (int k = 1; k <= 8; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (pair_valid && lat == 0) lat = k;
        end
        chk("pv_latency", 32'(lat), 32'(4));
      end
      tick(hp);
    end
  endtask

  task automatic send_pkt(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2);
    send_frame(32'(w0), W, 5, 1'b1, 1'b0);
    send_frame(32'(w1), W, 5, 1'b1, 1'b0);
    send_frame(32'(w2), W, 5, 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pairs pending, expected 0", sb.size());
      sb.delete();
    end
    tick(8);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_ad1"}, 32'(ad1), 32'(0));
    chk({tag, "_ad2"}, 32'(ad2), 32'(0));
    chk({tag, "_pv"}, 32'(pair_valid), 32'(0));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int pv0;
    int fe0;

    vt[0] = '{14'h0FFF, 14'h0000, 14'h3FFF, 1'b1, 14'h0000, 14'h3FFF, 0};
    vt[1] = '{14'h0FFF, 14'h3FFF, 14'h0000, 1'b1, 14'h3FFF, 14'h0000, 0};
    vt[2] = '{14'h0FFF, 14'h2AAA, 14'h1555, 1'b1, 14'h2AAA, 14'h1555, 0};
    vt[3] = '{14'h0FFF, 14'h0001, 14'h2000, 1'b1, 14'h0001, 14'h2000, 0};
`ifdef SPI_RX_HDR_CHECK_EN
    vt[4] = '{14'h0AAA, 14'h0123, 14'h0456, 1'b0, 14'h0000, 14'h0000, 3};
`else
    vt[4] = '{14'h0AAA, 14'h0123, 14'h0456, 1'b1, 14'h0123, 14'h0456, 0};
`endif

    rstn = 1'b0;
    cs   = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1 rstn = 1'b1;
    tick(10);
    chk("post_rst_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("post_rst_busy", 32'(busy), 32'(0));

    // basic packet with a slower sck, measuring cs-rise to pair_valid
    sb.push_back('{a1: 14'h054B, a2: 14'h054C});
    send_frame(32'h0FFF, W, 20, 1'b1, 1'b0);
    chk("busy_after_hdr", 32'(busy), 32'(1));
    send_frame(32'h054B, W, 20, 1'b1, 1'b0);
    send_frame(32'h054C, W, 20, 1'b1, 1'b1);
    wait_drain();
    chk("basic_busy", 32'(busy), 32'(0));
    chk("basic_ferr", 32'(n_ferr), 32'(exp_ferr));

    for (int v = 0; v < 5; v++) begin
      if (vt[v].pv) sb.push_back('{a1: vt[v].e1, a2: vt[v].e2});
      exp_ferr += vt[v].errs;
      send_pkt(vt[v].w0, vt[v].w1, vt[v].w2);
      wait_drain();
      chk("tbl_ferr", 32'(n_ferr), 32'(exp_ferr));
      chk("tbl_busy", 32'(busy), 32'(0));
    end

    pv0 = n_pv;
    fe0 = n_ferr;
    for (int a = 1355; a <= 2035; a += 20) begin
      sb.push_back('{a1: W'(a), a2: W'(a + 1)});
      send_pkt(14'h0FFF, W'(a), W'(a + 1));
    end
    wait_drain();
    chk("sweep_count", 32'(n_pv - pv0), 32'(35));
    chk("sweep_ferr", 32'(n_ferr - fe0), 32'(0));
    chk("sweep_last_ad1", 32'(ad1), 32'h07F3);
    chk("sweep_last_ad2", 32'(ad2), 32'h07F4);

    // short frame while waiting for AD_1
    send_frame(32'h0FFF, W, 5, 1'b1, 1'b0);
    chk("short_busy_pre", 32'(busy), 32'(1));
    send_frame(32'h02A5, 10, 5, 1'b1, 1'b0);
    exp_ferr++;
    tick(8);
    chk("short_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("short_busy", 32'(busy), 32'(0));
    chk("short_ad1", 32'(ad1), 32'h07F3);
    chk("short_ad2", 32'(ad2), 32'h07F4);
    sb.push_back('{a1: 14'h0100, a2: 14'h0101});
    send_pkt(14'h0FFF, 14'h0100, 14'h0101);
    wait_drain();
    chk("short_recover_ferr", 32'(n_ferr), 32'(exp_ferr));

    // long frame (counter saturates) while waiting for AD_2
    send_frame(32'h0FFF, W, 5, 1'b1, 1'b0);
    send_frame(32'h1234, W, 5, 1'b1, 1'b0);
    chk("long_busy_pre", 32'(busy), 32'(1));
    send_frame(32'hBEEF, 16, 5, 1'b1, 1'b0);
    exp_ferr++;
    tick(8);
    chk("long_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("long_busy", 32'(busy), 32'(0));
    chk("long_ad1", 32'(ad1), 32'h0100);
    chk("long_ad2", 32'(ad2), 32'h0101);

    // reset in the middle of AD_1
    send_frame(32'h0FFF, W, 5, 1'b1, 1'b0);
    send_frame(32'h0ABC, 7, 5, 1'b0, 1'b0);
    chk("midrst_busy_pre", 32'(busy), 32'(1));
    rstn = 1'b0;
    chk_reset_outputs("midrst");
    tick(9);
    rstn = 1'b1;
    tick(3);
    cs = 1'b1;
    tick(10);
    exp_ferr = n_ferr;
    chk("midrst_busy_post", 32'(busy), 32'(0));
    sb.push_back('{a1: 14'h0010, a2: 14'h0011});
    send_pkt(14'h0FFF, 14'h0010, 14'h0011);
    wait_drain();
    chk("midrst_ferr", 32'(n_ferr), 32'(exp_ferr));

    // header resynchronisation
`ifdef SPI_RX_HDR_CHECK_EN
    sb.push_back('{a1: 14'h0200, a2: 14'h0201});
    exp_ferr += 2;
`else
    sb.push_back('{a1: 14'h0123, a2: 14'h0FFF});
`endif
    send_frame(32'h0AAA, W, 5, 1'b1, 1'b0);
    send_frame(32'h0123, W, 5, 1'b1, 1'b0);
    send_pkt(14'h0FFF, 14'h0200, 14'h0201);
    wait_drain();
    chk("hdr_ferr", 32'(n_ferr), 32'(exp_ferr));
`ifdef SPI_RX_HDR_CHECK_EN
    chk("hdr_busy", 32'(busy), 32'(0));
`else
    chk("hdr_busy", 32'(busy), 32'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
